// File: rtl/issuer_pkg.sv
// Shared types and constants for the job issuer: FSM encoding, operand count, timeout counter width.
package issuer_pkg;

    localparam int unsigned OP_COUNT = 4;
    localparam int unsigned TMO_W    = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_START,
        ST_WAIT,
        ST_OUTPUT
    } state_t;

endpackage

// File: rtl/job_fifo.sv
// Circular job buffer with wrap-around pointers, a separate occupancy count and registered flags.
module job_fifo #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         empty,
    output logic         full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          push_en;
    logic          pop_en;

    assign push_en   = push && !full;
    assign pop_en    = pop && !empty;
    assign count_nxt = count + CW'(push_en) - CW'(pop_en);
    assign pop_data  = mem[rd_ptr];

    // Flags are registered from the next count so they are clean flop outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            empty <= (count_nxt == CW'(0));
            full  <= (count_nxt == CW'(DEPTH));
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/job_issuer.sv
// Sequences queued operand sets through the start/done worker: reset, start, wait with timeout, return result.
module job_issuer
    import issuer_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [OP_COUNT*DATA_W-1:0] in_data,
    output logic                       wrk_rst,
    output logic                       wrk_start,
    input  logic                       wrk_done,
    output logic [OP_COUNT*DATA_W-1:0] wrk_ops,
    input  logic [DATA_W-1:0]          wrk_result,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_timeout,
    output logic                       busy,
    output logic [TMO_W-1:0]           tmo_count
);

    localparam int unsigned OPS_W = OP_COUNT * DATA_W;
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t             state;
    state_t             state_nxt;
    logic               fifo_empty;
    logic               fifo_full;
    logic [OPS_W-1:0]   fifo_data;
    logic               pop;
    logic               capture_done;
    logic               capture_tmo;
    logic               wrk_rst_nxt;
    logic               wrk_start_nxt;
    logic               out_valid_nxt;
    logic               busy_nxt;
    logic [CNT_W-1:0]   wait_cnt;
    logic               wait_last;

    assign in_ready  = !fifo_full;
    assign wait_last = (wait_cnt == CNT_W'(TIMEOUT - 1));

    job_fifo #(
        .W     (OPS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid),
        .push_data (in_data),
        .pop       (pop),
        .pop_data  (fifo_data),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic; done has priority over the timeout in WAIT.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (!fifo_empty) state_nxt = ST_CLEAR;
            ST_CLEAR:  state_nxt = ST_START;
            ST_START:  state_nxt = ST_WAIT;
            ST_WAIT:   if (wrk_done || wait_last) state_nxt = ST_OUTPUT;
            ST_OUTPUT: if (out_ready) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Output decode: strobes for the datapath and next values of the registered outputs.
    always_comb begin
        pop           = 1'b0;
        capture_done  = 1'b0;
        capture_tmo   = 1'b0;
        wrk_rst_nxt   = (state_nxt == ST_CLEAR);
        wrk_start_nxt = (state_nxt == ST_START);
        out_valid_nxt = (state_nxt == ST_OUTPUT);
        busy_nxt      = (state_nxt != ST_IDLE);
        unique case (state)
            ST_IDLE: pop = !fifo_empty;
            ST_WAIT: begin
                if (wrk_done)       capture_done = 1'b1;
                else if (wait_last) capture_tmo  = 1'b1;
            end
            default: ;
        endcase
    end

    // Registered outputs, operand hold register and WAIT cycle counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wrk_rst     <= 1'b1;
            wrk_start   <= 1'b0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            wrk_ops     <= '0;
            out_data    <= '0;
            out_timeout <= 1'b0;
            tmo_count   <= '0;
            wait_cnt    <= '0;
        end else begin
            wrk_rst   <= wrk_rst_nxt;
            wrk_start <= wrk_start_nxt;
            out_valid <= out_valid_nxt;
            busy      <= busy_nxt;
            if (pop) wrk_ops <= fifo_data;
            if (state == ST_START)     wait_cnt <= '0;
            else if (state == ST_WAIT) wait_cnt <= wait_cnt + CNT_W'(1);
            if (capture_done) begin
                out_data    <= wrk_result;
                out_timeout <= 1'b0;
            end else if (capture_tmo) begin
                out_data    <= '0;
                out_timeout <= 1'b1;
                if (tmo_count != '1) tmo_count <= tmo_count + TMO_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_job_issuer.sv
// Directed bench for job_issuer with a behavioural worker whose result is operand 1 of the job.
module tb_job_issuer;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        wrk_rst;
    logic        wrk_start;
    logic        wrk_done;
    logic [31:0] wrk_ops;
    logic [7:0]  wrk_result;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_timeout;
    logic        busy;
    logic [7:0]  tmo_count;

    always #5 clk = ~clk;

    job_issuer #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .wrk_rst     (wrk_rst),
        .wrk_start   (wrk_start),
        .wrk_done    (wrk_done),
        .wrk_ops     (wrk_ops),
        .wrk_result  (wrk_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_timeout (out_timeout),
        .busy        (busy),
        .tmo_count   (tmo_count)
    );

    // Worker: done becomes visible in WAIT cycle number wk_lat, sticky until wrk_rst.
    int         wk_lat = 1000;
    int         wk_cnt = 0;
    logic       wk_act = 1'b0;
    logic       wk_done = 1'b0;
    logic [7:0] wk_res = 8'h00;

    always @(posedge clk) begin
        if (wrk_rst) begin
            wk_act  <= 1'b0;
            wk_done <= 1'b0;
            wk_cnt  <= 0;
        end else if (wrk_start) begin
            wk_act <= 1'b1;
            wk_cnt <= 0;
            wk_res <= wrk_ops[15:8];
            if (wk_lat == 0) wk_done <= 1'b1;
        end else if (wk_act && !wk_done) begin
            wk_cnt <= wk_cnt + 1;
            if (wk_cnt + 1 == wk_lat) wk_done <= 1'b1;
        end
    end

    assign wrk_done   = wk_done;
    assign wrk_result = wk_done ? wk_res : 8'hEE;

    // Observer on the falling edge: pulse counts, WAIT length, accepted results.
    int         n_start = 0;
    int         n_rst_cyc = 0;
    int         n_rst_pulse = 0;
    int         seq_err = 0;
    int         wcnt = 0;
    int         last_wait = -1;
    logic       prev_rst = 1'b0;
    logic       in_job = 1'b0;
    logic [8:0] res_q [$];

    always @(negedge clk) begin
        if (wrk_start === 1'b1) n_start++;
        if (wrk_rst === 1'b1) n_rst_cyc++;
        if (wrk_rst === 1'b1 && !prev_rst) n_rst_pulse++;
        if (wrk_start === 1'b1 && !prev_rst) seq_err++;
        prev_rst = (wrk_rst === 1'b1);
        if (!rst) in_job = 1'b0;
        else if (wrk_start === 1'b1) begin
            in_job = 1'b1;
            wcnt   = 0;
        end else if (in_job && !out_valid) wcnt++;
        else if (in_job) begin
            last_wait = wcnt;
            in_job    = 1'b0;
        end
        if (out_valid === 1'b1 && out_ready) res_q.push_back({out_timeout, out_data});
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [31:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 200) begin
            step(1);
            n++;
        end
        chk("push_ready", 32'(in_ready), 32'h1);
        step(1);
        in_valid = 1'b0;
    endtask

    task automatic wait_res(input int n, input int budget);
        int k = 0;
        while (res_q.size() < n && k < budget) begin
            step(1);
            k++;
        end
        chk("res_wait", 32'(res_q.size()), 32'(n));
    endtask

    function automatic logic [8:0] get_res(input int i);
        if (i < res_q.size()) return res_q[i];
        return 9'h1FF;
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'h1);
        chk({tag, "_wrk_rst"}, 32'(wrk_rst), 32'h1);
        chk({tag, "_wrk_start"}, 32'(wrk_start), 32'h0);
        chk({tag, "_wrk_ops"}, wrk_ops, 32'h0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'h0);
        chk({tag, "_out_data"}, 32'(out_data), 32'h0);
        chk({tag, "_out_timeout"}, 32'(out_timeout), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_tmo_count"}, 32'(tmo_count), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] r;
        int s0, p0, c0, k;

        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        step(3);
        chk_reset_vals("rst");
        rst = 1'b1;
        step(2);
        chk("idle_wrk_rst", 32'(wrk_rst), 32'h0);

        // Single job {3,5,5,9}, done visible in WAIT cycle 6.
        wk_lat = 6;
        s0 = n_start; p0 = n_rst_pulse; c0 = n_rst_cyc;
        push(32'h0905_0503);
        wait_res(1, 100);
        step(2);
        r = get_res(0);
        chk("single_data", 32'(r[7:0]), 32'h05);
        chk("single_tmo", 32'(r[8]), 32'h0);
        chk("single_starts", 32'(n_start - s0), 32'h1);
        chk("single_rst_pulses", 32'(n_rst_pulse - p0), 32'h1);
        chk("single_rst_cycles", 32'(n_rst_cyc - c0), 32'h1);
        chk("single_wait_len", 32'(last_wait), 32'h7);
        chk("single_ops", wrk_ops, 32'h0905_0503);
        chk("single_idle", 32'(busy), 32'h0);

        // First job stalls in OUTPUT, FIFO fills with four more, fifth is refused.
        out_ready = 1'b0;
        wk_lat    = 2;
        push(32'h0000_1100);
        k = 0;
        while (!out_valid && k < 50) begin
            step(1);
            k++;
        end
        chk("stall_valid", 32'(out_valid), 32'h1);
        s0 = n_start;
        push(32'h0000_2200);
        push(32'h0000_3300);
        push(32'h0000_4400);
        push(32'h0000_5500);
        chk("full_in_ready", 32'(in_ready), 32'h0);
        in_valid = 1'b1;
        in_data  = 32'h0000_6600;
        step(3);
        in_valid = 1'b0;
        step(4);
        chk("stall_valid_held", 32'(out_valid), 32'h1);
        chk("stall_data", 32'(out_data), 32'h11);
        chk("stall_ops", wrk_ops, 32'h0000_1100);
        chk("stall_no_start", 32'(n_start - s0), 32'h0);
        chk("stall_busy", 32'(busy), 32'h1);
        out_ready = 1'b1;
        wait_res(6, 300);
        step(40);
        chk("full_count", 32'(res_q.size()), 32'h6);
        for (int i = 1; i <= 5; i++) begin
            r = get_res(i);
            chk($sformatf("order_data%0d", i), 32'(r[7:0]), 32'(8'h11 * i));
            chk($sformatf("order_tmo%0d", i), 32'(r[8]), 32'h0);
        end

        // Worker never finishes: full TIMEOUT wait, zero result, counter bumps.
        wk_lat = 1000;
        push(32'h0000_7700);
        wait_res(7, 200);
        step(1);
        r = get_res(6);
        chk("tmo_data", 32'(r[7:0]), 32'h0);
        chk("tmo_flag", 32'(r[8]), 32'h1);
        chk("tmo_count1", 32'(tmo_count), 32'h1);
        chk("tmo_wait_len", 32'(last_wait), 32'd64);

        // Next job completes normally.
        wk_lat = 3;
        push(32'h0000_1200);
        wait_res(8, 100);
        step(1);
        r = get_res(7);
        chk("after_tmo_data", 32'(r[7:0]), 32'h12);
        chk("after_tmo_flag", 32'(r[8]), 32'h0);
        chk("after_tmo_count", 32'(tmo_count), 32'h1);
        chk("after_tmo_wait_len", 32'(last_wait), 32'h4);

        // Done arrives on the last WAIT cycle: result wins over timeout.
        wk_lat = 63;
        push(32'h0000_3C00);
        wait_res(9, 200);
        step(1);
        r = get_res(8);
        chk("last_cycle_data", 32'(r[7:0]), 32'h3C);
        chk("last_cycle_flag", 32'(r[8]), 32'h0);
        chk("last_cycle_count", 32'(tmo_count), 32'h1);
        chk("last_cycle_wait_len", 32'(last_wait), 32'd64);

        // Reset while waiting with two jobs queued.
        wk_lat = 1000;
        push(32'h0000_A100);
        push(32'h0000_A200);
        push(32'h0000_A300);
        step(5);
        chk("mid_busy", 32'(busy), 32'h1);
        chk("mid_no_valid", 32'(out_valid), 32'h0);
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        chk_reset_vals("midrst");
        s0 = n_start;
        step(100);
        chk("post_rst_results", 32'(res_q.size()), 32'h9);
        chk("post_rst_no_start", 32'(n_start - s0), 32'h0);
        chk("post_rst_idle", 32'(busy), 32'h0);
        chk("start_after_rst", 32'(seq_err), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
